// File: rtl/seq_mag_comparator.sv
// rtl/seq_mag_comparator.sv - multi-cycle MSD-first magnitude comparator with early termination
// Optional signed compare selected by macro SIGNED_CMP_EN (adds the signed_mode port).
module seq_mag_comparator #(
   parameter  int WIDTH = 16,
   parameter  int DIGIT = 4,
   localparam int NDIG  = WIDTH / DIGIT,
   localparam int CW    = $clog2(NDIG) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SIGNED_CMP_EN
   input  logic             signed_mode,
`endif
   output logic             busy,
   output logic             done,
   output logic             a_gb,
   output logic             a_lb,
   output logic             a_eb,
   output logic [CW-1:0]    cycles
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sh_a, sh_b;
   logic [WIDTH-1:0] cap_a, cap_b;
   logic [WIDTH-1:0] msb_flip;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] dig_a, dig_b;
   logic             accept, finish, advance;

   // Flipping both MSBs maps two's-complement order onto unsigned order.
`ifdef SIGNED_CMP_EN
   assign msb_flip = WIDTH'(signed_mode) << (WIDTH - 1);
`else
   assign msb_flip = '0;
`endif

   assign cap_a = a ^ msb_flip;
   assign cap_b = b ^ msb_flip;
   assign dig_a = sh_a[WIDTH-1 -: DIGIT];
   assign dig_b = sh_b[WIDTH-1 -: DIGIT];
   assign busy  = (state == SCAN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SCAN;
               accept    = 1'b1;
            end
         end
         SCAN: begin
            if ((dig_a != dig_b) || (cnt == NDIG_C)) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a   <= '0;
         sh_b   <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         a_gb   <= 1'b0;
         a_lb   <= 1'b0;
         a_eb   <= 1'b0;
         cycles <= '0;
      end else begin
         done <= finish;
         if (accept) begin
            sh_a <= cap_a;
            sh_b <= cap_b;
            cnt  <= CW'(1);
         end else if (advance) begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt + 1'b1;
         end
         // Flags and cycles only move on completion so they hold between compares.
         if (finish) begin
            a_gb   <= (dig_a > dig_b);
            a_lb   <= (dig_a < dig_b);
            a_eb   <= (dig_a == dig_b);
            cycles <= cnt;
         end
      end
   end

endmodule
